// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM state type, scancode prefixes and default timeout for the PS/2 receiver.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam int TIMEOUT_CYC_DEF = 50000;
endpackage

// File: rtl/ps2_rx_ctrl_if.sv
// ps2_rx_ctrl_if: PS/2 pins in, decoded key events out.
interface ps2_rx_ctrl_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic       frame_err;
    modport master (output ps2_clk, ps2_data, input key_code, key_ext, key_break, key_valid, frame_err);
    modport slave  (input ps2_clk, ps2_data, output key_code, key_ext, key_break, key_valid, frame_err);
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchronizes the PS/2 pins into clk and flags falling edges of the PS/2 clock.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic sync_data_o,
    output logic fall_pulse_o
);
    logic [SYNC_STAGES-1:0] clk_q, data_q;
    logic prev_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_q  <= '1;
            data_q <= '1;
            prev_q <= 1'b1;
        end else begin
            clk_q  <= {clk_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_q <= {data_q[SYNC_STAGES-2:0], ps2_data_i};
            prev_q <= clk_q[SYNC_STAGES-1];
        end
    end
    assign sync_data_o  = data_q[SYNC_STAGES-1];
    assign fall_pulse_o = prev_q & ~clk_q[SYNC_STAGES-1];
endmodule

// File: rtl/ps2_rx_ctrl.sv
// ps2_rx_ctrl: PS/2 keyboard frame receiver with E0/F0 prefix folding and inter-edge timeout.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst_n,
    ps2_rx_ctrl_if.slave bus
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic sdata, fall, timeout, par_ok;
    state_e state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] byte_q, byte_d, code_q, code_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic par_q, par_d, ext_q, ext_d, brk_q, brk_d;
    logic kext_q, kext_d, kbrk_q, kbrk_d, valid_q, valid_d, err_q, err_d;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst_n(rst_n), .ps2_clk_i(bus.ps2_clk), .ps2_data_i(bus.ps2_data),
        .sync_data_o(sdata), .fall_pulse_o(fall)
    );

    assign timeout = tmo_q == TW'(TIMEOUT_CYC - 1);
    assign par_ok  = sdata & (^byte_q ^ par_q);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        par_d   = par_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        code_d  = code_q;
        kext_d  = kext_q;
        kbrk_d  = kbrk_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        tmo_d   = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);
        if (fall) begin
            case (state_q)
                IDLE: if (!sdata) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
                DATA: begin
                    byte_d  = {sdata, byte_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = sdata;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    // Prefixes only arm flags; anything else completes a key event and consumes them.
                    if (par_ok && byte_q == PS2_EXT) ext_d = 1'b1;
                    else if (par_ok && byte_q == PS2_BRK) brk_d = 1'b1;
                    else begin
                        valid_d = par_ok;
                        err_d   = ~par_ok;
                        code_d  = par_ok ? byte_q : code_q;
                        kext_d  = par_ok ? ext_q : kext_q;
                        kbrk_d  = par_ok ? brk_q : kbrk_q;
                        ext_d   = 1'b0;
                        brk_d   = 1'b0;
                    end
                end
            endcase
        end else if (state_q != IDLE && timeout) begin
            state_d = IDLE;
            tmo_d   = '0;
            err_d   = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bit_q   <= '0;
            byte_q  <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            code_q  <= '0;
            kext_q  <= 1'b0;
            kbrk_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            code_q  <= code_d;
            kext_q  <= kext_d;
            kbrk_q  <= kbrk_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.key_code  = code_q;
    assign bus.key_ext   = kext_q;
    assign bus.key_break = kbrk_q;
    assign bus.key_valid = valid_q;
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// tb_ps2_rx_ctrl: directed PS/2 frames checked against an event-queue model of the decoder.
module tb_ps2_rx_ctrl;
    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    ev_t exp_q[$];
    logic m_ext = 1'b0, m_brk = 1'b0;
    logic [7:0] held_code = 8'h00;
    logic held_ext = 1'b0, held_brk = 1'b0;

    ps2_rx_ctrl_if bus ();
    ps2_rx_ctrl #(.TIMEOUT_CYC(100), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        wait_clk(5);
        bus.ps2_clk = 1'b0;
        wait_clk(5);
        bus.ps2_clk = 1'b1;
    endtask

    // Frame-level model: what a completed frame must produce, independent of how it is decoded.
    task automatic model_frame(input logic [7:0] b, input logic good);
        if (!good) begin
            exp_q.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            exp_q.push_back('{1'b0, b, m_ext, m_brk});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_par);
        model_frame(b, !bad_par && !bad_stop);
        ps2_bit(~bad_stop);
        wait_clk(10);
        chk("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("no_dual_strobe", {31'd0, bus.key_valid & bus.frame_err}, 0);
            if (bus.key_valid) begin
                if (exp_q.size() == 0 || exp_q[0].err) chk("unexpected_valid", 1, 0);
                else begin
                    held_code = exp_q[0].code;
                    held_ext  = exp_q[0].ext;
                    held_brk  = exp_q[0].brk;
                    void'(exp_q.pop_front());
                end
            end
            if (bus.frame_err) begin
                if (exp_q.size() == 0 || !exp_q[0].err) chk("unexpected_err", 1, 0);
                else void'(exp_q.pop_front());
            end
            chk("key_code", bus.key_code, held_code);
            chk("key_ext", bus.key_ext, held_ext);
            chk("key_break", bus.key_break, held_brk);
        end
    end

    initial begin
        int n;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_clk(3);
        chk("rst_outputs", {bus.key_code, bus.key_ext, bus.key_break, bus.key_valid, bus.frame_err}, 0);
        rst_n = 1'b1;
        wait_clk(5);

        send(8'h1C, 1'b0, 1'b0);
        chk("lit_1c", {bus.key_code, bus.key_ext, bus.key_break}, {8'h1C, 2'b00});
        send(8'hF0, 1'b0, 1'b0);
        send(8'h1C, 1'b0, 1'b0);
        chk("lit_f0_1c", {bus.key_code, bus.key_ext, bus.key_break}, {8'h1C, 2'b01});
        send(8'hE0, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 1'b0);
        send(8'h75, 1'b0, 1'b0);
        chk("lit_e0_f0_75", {bus.key_code, bus.key_ext, bus.key_break}, {8'h75, 2'b11});
        send(8'hE0, 1'b0, 1'b0);
        send(8'h6B, 1'b0, 1'b0);
        send(8'h45, 1'b1, 1'b0);
        chk("lit_bad_par_hold", bus.key_code, 8'h6B);
        send(8'h16, 1'b0, 1'b0);
        chk("lit_16", bus.key_code, 8'h16);
        send(8'hF0, 1'b0, 1'b0);
        send(8'h3A, 1'b0, 1'b1);
        send(8'h3A, 1'b0, 1'b0);
        chk("lit_stop_err_clears_brk", {bus.key_code, bus.key_break}, {8'h3A, 1'b0});
        ps2_bit(1'b1);
        wait_clk(10);
        chk("idle_high_edge_silent", exp_q.size(), 0);

        // Timeout: 4 data bits then silence; 2 sync stages + edge register + 100 counter cycles.
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        bus.ps2_data = 1'b0;
        wait_clk(5);
        model_frame(8'h00, 1'b0);
        bus.ps2_clk = 1'b0;
        n = 0;
        while (n < 300 && !bus.frame_err) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 5) bus.ps2_clk = 1'b1;
        end
        chk("timeout_latency", n, 103);
        wait_clk(10);
        chk("timeout_drain", exp_q.size(), 0);
        send(8'h29, 1'b0, 1'b0);
        chk("lit_29", bus.key_code, 8'h29);

        send(8'hF0, 1'b0, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i[0] ? 1'b0 : 1'b1);
        rst_n = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        held_code = 8'h00;
        held_ext = 1'b0;
        held_brk = 1'b0;
        exp_q.delete();
        wait_clk(3);
        chk("midframe_rst", {bus.key_code, bus.key_ext, bus.key_break, bus.key_valid, bus.frame_err}, 0);
        rst_n = 1'b1;
        wait_clk(5);
        send(8'h1C, 1'b0, 1'b0);
        chk("lit_post_rst", {bus.key_code, bus.key_ext, bus.key_break}, {8'h1C, 2'b00});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
